// File: rtl/led_matrix_driver.sv
// led_matrix_driver: serial-in 16-bit LED line driver.
// The din/dclk/strobe pins are synchronized. Each dclk rise shifts one bit into a
// 16-bit shift register. Each strobe rise copies that register into the display
// latch and starts a blanking window. The outputs stay dark while the window runs.
// Optional build macro: OUT_INVERT_EN makes the LED outputs active-low.
module led_matrix_driver #(
  parameter int SYNC_STAGES    = 2,
  parameter int BLANK_PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // The longest window is 31 units of BLANK_PRESCALE clocks, so the counter is sized to hold it.
  localparam int BW = $clog2(31 * BLANK_PRESCALE + 1);

  logic [2:0]    w_raw;
  logic [2:0]    w_sync;
  logic          w_din_s;
  logic          w_dclk_s;
  logic          w_strobe_s;
  logic          w_shift;
  logic          w_latch;
  logic [BW-1:0] w_blank_load;
  logic [15:0]   w_disp_vis;
  logic          w_unused;

  logic          r_dclk_prev;
  logic          r_strobe_prev;
  logic [4:0]    r_blank_time;
  logic [15:0]   r_sr;
  logic [15:0]   r_disp;
  logic [BW-1:0] r_blank_cnt;

  // Bit 0 is din, bit 1 is dclk and bit 2 is strobe.
  // All three use chains of the same depth, so din stays aligned with dclk.
  assign w_raw = ui_in[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_chain;
      // Each input pin goes through its own shift chain of synchronizer flops.
      always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= {r_chain[SYNC_STAGES-2:0], w_raw[gi]};
      end
      assign w_sync[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  assign w_din_s    = w_sync[0];
  assign w_dclk_s   = w_sync[1];
  assign w_strobe_s = w_sync[2];

  // A pulse fires only on a rising edge, and only after the synchronizer has already seen the line low.
  assign w_shift = w_dclk_s & ~r_dclk_prev;
  assign w_latch = w_strobe_s & ~r_strobe_prev;

  assign w_blank_load = BW'(r_blank_time) * BW'(BLANK_PRESCALE);

  // Keep the edge history and the registered blank-time field.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dclk_prev   <= 1'b0;
      r_strobe_prev <= 1'b0;
      r_blank_time  <= '0;
    end else begin
      r_dclk_prev   <= w_dclk_s;
      r_strobe_prev <= w_strobe_s;
      r_blank_time  <= ui_in[7:3];
    end
  end

  // Shift register. The latch reads the value from before a shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          r_sr <= '0;
    else if (w_shift) r_sr <= {r_sr[14:0], w_din_s};
  end

  // Display latch and blanking counter. A new strobe restarts an active window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp      <= '0;
      r_blank_cnt <= '0;
    end else if (w_latch) begin
      r_disp      <= r_sr;
      r_blank_cnt <= w_blank_load;
    end else if (r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - 1'b1;
    end
  end

  assign w_disp_vis = (r_blank_cnt != '0) ? 16'h0000 : r_disp;

`ifdef OUT_INVERT_EN
  // Common-anode LEDs: a lit LED drives its line low, so a dark display drives every line high.
  assign {uio_out, uo_out} = ~w_disp_vis;
`else
  assign {uio_out, uo_out} = w_disp_vis;
`endif

  assign uio_oe = 8'hFF;

  // ena and the bidirectional inputs have no function in this block.
  assign w_unused = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_led_matrix_driver.sv
// Testbench for led_matrix_driver.
// A behavioural model tracks the serial word, the latched word and the blank length.
// The bench compares the model against the LED outputs cycle by cycle around each strobe.
module tb_led_matrix_driver;

  localparam int SS = 2;
  localparam int PS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [15:0] w_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_sr;
  logic [15:0] m_disp;

  always #5 clk = ~clk;

  led_matrix_driver #(.SYNC_STAGES(SS), .BLANK_PRESCALE(PS)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  assign w_out = {uio_out, uo_out};

  function automatic logic [15:0] vis(input logic [15:0] v);
`ifdef OUT_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One slow dclk cycle carrying bit b; the model shifts on the dclk rise.
  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 ui_in[0] = b;
    clks(4);
    #1 ui_in[1] = 1'b1;
    m_sr = {m_sr[14:0], b};
    clks(8);
    #1 ui_in[1] = 1'b0;
    clks(4);
  endtask

  // Send n bits of w, most significant bit first.
  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    $display("[TB] shifted %0d bits, model sr=%h", n, m_sr);
  endtask

  // Raise strobe. The old view must hold through the synchronizer latency.
  // Then the outputs must stay dark for bt*PS cycles and show the latched word afterwards.
  task automatic do_strobe(input logic [4:0] bt, input bit pre_blank, input bit full);
    logic [15:0] pre;
    int nb;
    pre = pre_blank ? 16'h0000 : m_disp;
    ui_in[7:3] = bt;
    clks(2);
    #1 ui_in[2] = 1'b1;
    for (int i = 0; i < SS + 1; i++) begin
      @(negedge clk);
      chk("pre_latch", w_out, vis(pre));
    end
    m_disp = m_sr;
    nb = int'(bt) * PS;
    if (!full && nb > 5) nb = 5;
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      chk("blank", w_out, vis(16'h0000));
    end
    if (full) begin
      @(negedge clk);
      chk("latched", w_out, vis(m_disp));
    end
    ui_in[2] = 1'b0;
    $display("[TB] strobe blank=%0d disp=%h out=%h", bt, m_disp, w_out);
  endtask

  initial begin
    logic [31:0] w;
    int nbits;
    logic [4:0] bt;

    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    m_sr = 16'h0; m_disp = 16'h0;
    clks(3);
    @(negedge clk);
    chk("reset_out", w_out, vis(16'h0000));
    chk("reset_oe", {8'h00, uio_oe}, 16'h00FF);
    @(posedge clk);
    #1 rst = 1'b0;
    clks(2);

    // Strobe with no shifts still shows zero.
    do_strobe(5'd0, 1'b0, 1'b1);

    // A5C3 with no blanking.
    send_word(32'hA5C3, 16);
    do_strobe(5'd0, 1'b0, 1'b1);
    chk("pattern_a5c3", w_out, vis(16'hA5C3));

    // 00FF with a 5-cycle blank.
    send_word(32'h00FF, 16);
    do_strobe(5'd5, 1'b0, 1'b1);

    // Send 20 bits; only the last 16 survive. Later shifts must not reach the outputs.
    send_word(32'h000F1234, 20);
    do_strobe(5'd0, 1'b0, 1'b1);
    chk("last16", w_out, vis(16'h1234));
    send_word(32'h1B, 5);
    @(negedge clk);
    chk("no_strobe_hold", w_out, vis(16'h1234));
    chk("oe_const", {8'h00, uio_oe}, 16'h00FF);

    // A second strobe during an active blank restarts the window.
    send_word(32'h5A5A, 16);
    ui_in[7:3] = 5'd20;
    clks(2);
    #1 ui_in[2] = 1'b1;
    for (int i = 0; i < SS + 1; i++) begin
      @(negedge clk);
      chk("restart_pre", w_out, vis(m_disp));
    end
    m_disp = m_sr;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("restart_blank", w_out, vis(16'h0000));
    end
    ui_in[2] = 1'b0;
    clks(2);
    do_strobe(5'd3, 1'b1, 1'b1);

    // dclk and strobe rise together: the latch takes the old sr, and the shift still happens.
    ui_in[7:3] = 5'd0;
    @(posedge clk);
    #1 ui_in[0] = 1'b1;
    clks(4);
    #1 ui_in[1] = 1'b1; ui_in[2] = 1'b1;
    for (int i = 0; i < SS + 1; i++) begin
      @(negedge clk);
      chk("same_pre", w_out, vis(m_disp));
    end
    m_disp = m_sr;
    m_sr = {m_sr[14:0], 1'b1};
    @(negedge clk);
    chk("same_latch_old", w_out, vis(m_disp));
    ui_in[1] = 1'b0; ui_in[2] = 1'b0;
    clks(4);
    do_strobe(5'd0, 1'b0, 1'b1);

    // Reset in the middle of a blank and after further shifting.
    send_word(32'hFFFF, 16);
    do_strobe(5'd31, 1'b0, 1'b0);
    send_bit(1'b1);
    @(posedge clk);
    #1 ui_in[0] = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", w_out, vis(16'h0000));
    chk("rst_mid_oe", {8'h00, uio_oe}, 16'h00FF);
    @(posedge clk);
    #1 rst = 1'b0; ui_in = 8'h00;
    m_sr = 16'h0; m_disp = 16'h0;
    clks(2);
    do_strobe(5'd0, 1'b0, 1'b1);

    // Randomized transactions.
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      nbits = $urandom_range(1, 20);
      bt = 5'($urandom_range(0, 12));
      send_word(w, nbits);
      do_strobe(bt, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
